demux8_deser: RTL
=================

DEMUX8_DESER -- requirements
Module: demux8_deser

Interface
REQ-001 The module SHALL have one clock, clk; reset is synchronous and active-low (rst_n).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 din  input  1  serial data bit.
REQ-005 din_valid  input  1  din is sampled on this edge when high; state holds when low.
REQ-006 sof  input  1  start-of-frame; qualified by din_valid; marks the current bit as bit 0.
REQ-007 q  output  8  deserialized word; q[0] is the first bit received.
REQ-008 q_valid  output  1  q holds an unconsumed word.
REQ-009 q_ready  input  1  consumer accepts q when q_valid and q_ready are both high on an edge.
REQ-010 busy  output  1  frame in progress, bit count 1..7 (or 1..8 with parity).
REQ-011 ovf  output  1  sticky overrun flag.
REQ-012 parity_err  output  1  pulse on frame completion with bad parity; constant 0 without DEMUX8_PARITY_EN.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT and, with parity, PAR.
REQ-014 IDLE: on din_valid&sof, write din to shift bit 0, set count=1, go to SHIFT; din_valid without sof is ignored.
REQ-015 SHIFT: on each din_valid, write din to shift bit [count] and increment count; 3-bit count wraps 7->0 on frame completion.
REQ-016 Frame completes on the edge that captures bit 7, or the parity bit with DEMUX8_PARITY_EN; next state is IDLE.
REQ-017 din_valid&sof in SHIFT or PAR SHALL abort the partial frame and restart at bit 0 with count=1; the partial frame is not delivered.
REQ-018 On completion, q/q_valid update on the same edge: q_valid visible the cycle after the last bit is sampled (latency 1 clock).
REQ-019 If q_valid=1 and q_ready=0 on the completion edge, the new word is dropped, q is unchanged and ovf is set.
REQ-020 If q_valid=1 and q_ready=1 on the completion edge, q loads the new word and q_valid stays 1 (no bubble, no overrun).
REQ-021 q_valid&q_ready without completion SHALL clear q_valid on that edge; q retains its value.
REQ-022 ovf SHALL stay set until reset.
REQ-023 busy SHALL be 1 exactly when state is not IDLE.

Reset
REQ-024 On rst_n=0 at a rising edge: state=IDLE, count=0, shift=0, q=8'h00, q_valid=0, busy=0, ovf=0, parity_err=0.
REQ-025 Reset mid-frame SHALL discard the partial frame; reset has priority over every other input.

Configuration
REQ-026 Macro DEMUX8_PARITY_EN defined: frames are 9 bits; bit 8 is even parity over the 8 data bits, received in state PAR; a mismatch pulses parity_err for one cycle on the completion edge and the word is still delivered under REQ-019/020.
REQ-027 DEMUX8_PARITY_EN undefined: frames are 8 bits, PAR is absent, parity_err is tied 0.

Verification
REQ-028 Reset, then sof+bits 1,0,1,1,0,0,1,0 on 8 consecutive din_valid cycles -> q=8'h4D, q_valid high one cycle after the 8th bit, busy low.
REQ-029 Same frame with din_valid low for 3 cycles between bits 4 and 5 -> q=8'h4D, completion delayed by exactly 3 cycles.
REQ-030 Word pending with q_ready=0, second frame 8'hFF completes -> q stays 8'h4D, ovf=1; q_ready=1 and frame 8'h0F completing on the same edge -> q=8'h0F, q_valid stays 1.
REQ-031 sof reasserted after 5 bits, then 8 bits of 8'hA5 -> only 8'hA5 delivered; rst_n=0 after 3 bits -> all outputs at reset values, no word delivered.
REQ-032 With DEMUX8_PARITY_EN: 8'h4D (four ones) with parity bit 0 -> parity_err stays 0; parity bit 1 -> parity_err pulses 1 cycle and q=8'h4D.

Source files
------------

// File: rtl/demux8_deser_if.sv
// Bundle for demux8_deser: serial input side plus the parallel word handshake and status.
// No logic; carries the registered outputs of the deserializer unchanged.
// q_valid/q_ready is a valid-ready pair; the serial side has no backpressure.
interface demux8_deser_if;
    logic       din;
    logic       din_valid;
    logic       sof;
    logic [7:0] q;
    logic       q_valid;
    logic       q_ready;
    logic       busy;
    logic       ovf;
    logic       parity_err;

    // Producer/consumer side (drives serial bits, accepts words)
    modport master (
        output din, din_valid, sof, q_ready,
        input  q, q_valid, busy, ovf, parity_err
    );

    // Deserializer side
    modport slave (
        input  din, din_valid, sof, q_ready,
        output q, q_valid, busy, ovf, parity_err
    );
endinterface

// File: rtl/demux8_deser.sv
// Serial-to-parallel deserializer: 8-bit frames, LSB first, framed by sof; optional even parity bit (DEMUX8_PARITY_EN).
// Latency: q/q_valid update on the edge that samples the last bit, visible one clock later.
// Backpressure: single-word output register; a word completing while q is unconsumed and q_ready is low is dropped and sets sticky ovf.
module demux8_deser (
    input  logic          clk,
    input  logic          rst_n,
    demux8_deser_if.slave bus
);

`ifdef DEMUX8_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t     state;
    logic [2:0] count;
    logic [7:0] shift;
    logic [7:0] q_r;
    logic       q_valid_r;
    logic       busy_r;
    logic       ovf_r;

    logic       start;
    logic       take_bit;
    logic       frame_done;
    logic [7:0] word;

`ifdef DEMUX8_PARITY_EN
    logic       par_bad;
    logic       par_err_r;
`endif

    // Decode this edge's action: frame start/restart, ordinary bit capture, frame completion and the completed word
    always_comb begin
        start      = bus.din_valid & bus.sof;
        take_bit   = bus.din_valid & ~bus.sof & (state != IDLE);
`ifdef DEMUX8_PARITY_EN
        // All 8 data bits are already in shift; din is the parity bit
        word       = shift;
        frame_done = take_bit & (state == PAR);
        par_bad    = (^shift) != bus.din;
`else
        // Last data bit arrives on the completion edge, merge it in directly
        word        = shift;
        word[count] = bus.din;
        frame_done  = take_bit & (state == SHIFT) & (count == 3'd7);
`endif
    end

    // FSM, shift register and registered outputs; reset wins over everything, sof restarts a frame from any state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= 3'd0;
            shift     <= 8'h00;
            q_r       <= 8'h00;
            q_valid_r <= 1'b0;
            busy_r    <= 1'b0;
            ovf_r     <= 1'b0;
`ifdef DEMUX8_PARITY_EN
            par_err_r <= 1'b0;
`endif
        end else begin
            if (start) begin
                // Any partial frame is discarded here and never delivered
                shift  <= {7'b0, bus.din};
                count  <= 3'd1;
                state  <= SHIFT;
                busy_r <= 1'b1;
            end else if (take_bit) begin
                case (state)
                    SHIFT: begin
                        shift[count] <= bus.din;
                        count        <= count + 3'd1;
                        if (count == 3'd7) begin
`ifdef DEMUX8_PARITY_EN
                            state  <= PAR;
                            busy_r <= 1'b1;
`else
                            state  <= IDLE;
                            busy_r <= 1'b0;
`endif
                        end
                    end
`ifdef DEMUX8_PARITY_EN
                    PAR: begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
`endif
                    default: begin
                        state <= state;
                    end
                endcase
            end

            // Output word register: load on completion if free or being consumed, else flag overrun
            if (frame_done) begin
                if (!q_valid_r || bus.q_ready) begin
                    q_r       <= word;
                    q_valid_r <= 1'b1;
                end else begin
                    ovf_r <= 1'b1;
                end
            end else if (q_valid_r && bus.q_ready) begin
                q_valid_r <= 1'b0;
            end

`ifdef DEMUX8_PARITY_EN
            par_err_r <= frame_done & par_bad;
`endif
        end
    end

    assign bus.q       = q_r;
    assign bus.q_valid = q_valid_r;
    assign bus.busy    = busy_r;
    assign bus.ovf     = ovf_r;
`ifdef DEMUX8_PARITY_EN
    assign bus.parity_err = par_err_r;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule
